// File: rtl/uart_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// uart_fifo_ctrl
//
// Pointer and flag controller for one UART TX or RX FIFO. It drives the write
// enable and the two addresses of a register-file storage block. That storage
// writes on the clock edge and reads combinationally, so the word at r_addr is
// the head of the queue whenever empty is low. The FIFO therefore behaves as
// first-word-fall-through.
//
// Parameters
//   ADDR_WIDTH : pointer width; the FIFO depth is DEPTH = 2**ADDR_WIDTH
//   AF_LEVEL   : almost_full is set when count >= AF_LEVEL
//   AE_LEVEL   : almost_empty is set when count <= AE_LEVEL
//
// Ports
//   clk          in   system clock; all state changes on the rising edge
//   rst_n        in   asynchronous active-low reset
//   clr          in   synchronous flush; overrides wr and rd
//   wr           in   push request (the producer drives data into the storage)
//   rd           in   pop request (the consumer takes the head word this cycle)
//   w_en         out  storage write enable (combinational, equals push_ok)
//   w_addr       out  storage write address (write pointer)
//   r_addr       out  storage read address (read pointer)
//   full         out  count == DEPTH, registered
//   empty        out  count == 0, registered
//   almost_full  out  count >= AF_LEVEL, registered
//   almost_empty out  count <= AE_LEVEL, registered
//   count        out  occupancy from 0 to DEPTH, registered
//   overflow     out  one-cycle pulse after a rejected push
//   underflow    out  one-cycle pulse after a rejected pop
// ---------------------------------------------------------------------------
module uart_fifo_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 14,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  wr,
  input  logic                  rd,
  output logic                  w_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  localparam logic [CW-1:0]         DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]         AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0]         AE_C    = CW'(AE_LEVEL);
  localparam logic [CW-1:0]         ONE_C   = CW'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_INC = ADDR_WIDTH'(1);

  // Refuse to elaborate with thresholds that make the almost flags meaningless.
  generate
    if (!(AE_LEVEL > 0 && AE_LEVEL < AF_LEVEL && AF_LEVEL < DEPTH)) begin : g_bad_levels
      $error("uart_fifo_ctrl: need 0 < AE_LEVEL < AF_LEVEL < DEPTH");
    end
  endgenerate

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] wptr_reg, wptr_next;
  logic [ADDR_WIDTH-1:0] rptr_reg, rptr_next;
  logic [CW-1:0]         count_reg, count_next;
  logic                  full_reg, full_next;
  logic                  empty_reg, empty_next;
  logic                  af_reg, af_next;
  logic                  ae_reg, ae_next;
  logic                  ovf_reg, ovf_next;
  logic                  unf_reg, unf_next;

  logic push_ok;
  logic pop_ok;

  // -------------------------------------------------------------------------
  // Accept decisions use only the registered flags, so wr and rd never reach
  // a flag output combinationally. A push into a full FIFO is accepted when a
  // pop happens in the same cycle, because the pop frees the slot at the same
  // edge. A pop from an empty FIFO is always rejected, even with a concurrent
  // push: the pushed word is not readable until the next cycle.
  // -------------------------------------------------------------------------
  always_comb begin
    push_ok = 1'b0;
    pop_ok  = 1'b0;
    if (!clr) begin
      push_ok = wr && (!full_reg || rd);
      pop_ok  = rd && !empty_reg;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    wptr_next  = wptr_reg;
    rptr_next  = rptr_reg;
    count_next = count_reg;
    ovf_next   = 1'b0;
    unf_next   = 1'b0;

    if (clr) begin
      // A flush discards the contents and also swallows any error pulse.
      wptr_next  = '0;
      rptr_next  = '0;
      count_next = '0;
    end else begin
      // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
      if (push_ok) wptr_next = wptr_reg + PTR_INC;
      if (pop_ok)  rptr_next = rptr_reg + PTR_INC;

      if (push_ok && !pop_ok) begin
        count_next = count_reg + ONE_C;
      end else if (pop_ok && !push_ok) begin
        count_next = count_reg - ONE_C;
      end

      ovf_next = wr && !push_ok;
      unf_next = rd && !pop_ok;
    end

    // Flags come from the next occupancy so that they are registered and
    // line up with count in the cycle after the edge that caused the change.
    full_next  = (count_next == DEPTH_C);
    empty_next = (count_next == '0);
    af_next    = (count_next >= AF_C);
    ae_next    = (count_next <= AE_C);
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
      full_reg  <= 1'b0;
      empty_reg <= 1'b1;
      af_reg    <= 1'b0;
      ae_reg    <= 1'b1;
      ovf_reg   <= 1'b0;
      unf_reg   <= 1'b0;
    end else begin
      wptr_reg  <= wptr_next;
      rptr_reg  <= rptr_next;
      count_reg <= count_next;
      full_reg  <= full_next;
      empty_reg <= empty_next;
      af_reg    <= af_next;
      ae_reg    <= ae_next;
      ovf_reg   <= ovf_next;
      unf_reg   <= unf_next;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // The storage captures the data at the same edge that advances wptr.
  assign w_en         = push_ok;
  assign w_addr       = wptr_reg;
  assign r_addr       = rptr_reg;
  assign full         = full_reg;
  assign empty        = empty_reg;
  assign almost_full  = af_reg;
  assign almost_empty = ae_reg;
  assign count        = count_reg;
  assign overflow     = ovf_reg;
  assign underflow    = unf_reg;

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
module tb_uart_fifo_ctrl;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       wr;
  logic       rd;
  logic       w_en;
  logic [3:0] w_addr;
  logic [3:0] r_addr;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  uart_fifo_ctrl #(.ADDR_WIDTH(4), .AF_LEVEL(14), .AE_LEVEL(2)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr(wr), .rd(rd),
    .w_en(w_en), .w_addr(w_addr), .r_addr(r_addr),
    .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Storage model: registered write, combinational read.
  logic [7:0] din;
  logic [7:0] mem [16];
  always @(posedge clk) if (w_en) mem[w_addr] <= din;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic wr, rd, clr;
    logic wen;
    int   cnt;
    logic fl, em, af, ae, ov, un;
    int   wa, ra;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic w, input logic r, input logic c, input logic wen,
                     input int cnt, input logic fl, input logic em,
                     input logic af, input logic ae, input logic ov, input logic un,
                     input int wa, input int ra);
    vec_t v;
    v.wr = w; v.rd = r; v.clr = c; v.wen = wen; v.cnt = cnt;
    v.fl = fl; v.em = em; v.af = af; v.ae = ae; v.ov = ov; v.un = un;
    v.wa = wa; v.ra = ra;
    vecs.push_back(v);
  endtask

  initial begin
    //   wr rd clr wen cnt fl em af ae ov un wa ra
    add(0, 0, 0, 0,  0, 0, 1, 0, 1, 0, 0,  0, 0);  // idle after reset
    add(0, 1, 0, 0,  0, 0, 1, 0, 1, 0, 1,  0, 0);  // pop empty
    add(1, 1, 0, 1,  1, 0, 0, 0, 1, 0, 1,  1, 0);  // wr+rd on empty
    add(1, 0, 0, 1,  2, 0, 0, 0, 1, 0, 0,  2, 0);
    add(1, 0, 0, 1,  3, 0, 0, 0, 0, 0, 0,  3, 0);
    add(1, 0, 0, 1,  4, 0, 0, 0, 0, 0, 0,  4, 0);
    add(1, 0, 0, 1,  5, 0, 0, 0, 0, 0, 0,  5, 0);
    add(1, 0, 0, 1,  6, 0, 0, 0, 0, 0, 0,  6, 0);
    add(1, 0, 0, 1,  7, 0, 0, 0, 0, 0, 0,  7, 0);
    add(1, 0, 0, 1,  8, 0, 0, 0, 0, 0, 0,  8, 0);
    add(1, 0, 0, 1,  9, 0, 0, 0, 0, 0, 0,  9, 0);
    add(1, 0, 0, 1, 10, 0, 0, 0, 0, 0, 0, 10, 0);
    add(1, 0, 0, 1, 11, 0, 0, 0, 0, 0, 0, 11, 0);
    add(1, 0, 0, 1, 12, 0, 0, 0, 0, 0, 0, 12, 0);
    add(1, 0, 0, 1, 13, 0, 0, 0, 0, 0, 0, 13, 0);
    add(1, 0, 0, 1, 14, 0, 0, 1, 0, 0, 0, 14, 0);  // almost_full threshold
    add(1, 0, 0, 1, 15, 0, 0, 1, 0, 0, 0, 15, 0);
    add(1, 0, 0, 1, 16, 1, 0, 1, 0, 0, 0,  0, 0);  // full, w_addr wraps
    add(1, 0, 0, 0, 16, 1, 0, 1, 0, 1, 0,  0, 0);  // push into full
    add(1, 1, 0, 1, 16, 1, 0, 1, 0, 0, 0,  1, 1);  // wr+rd on full
    add(0, 1, 0, 0, 15, 0, 0, 1, 0, 0, 0,  1, 2);
    add(1, 0, 1, 0,  0, 0, 1, 0, 1, 0, 0,  0, 0);  // clr wins over wr
    add(1, 1, 1, 0,  0, 0, 1, 0, 1, 0, 0,  0, 0);  // clr: no pulses
    add(1, 0, 0, 1,  1, 0, 0, 0, 1, 0, 0,  1, 0);
    add(1, 0, 0, 1,  2, 0, 0, 0, 1, 0, 0,  2, 0);
    add(1, 0, 0, 1,  3, 0, 0, 0, 0, 0, 0,  3, 0);
    add(0, 1, 0, 0,  2, 0, 0, 0, 1, 0, 0,  3, 1);

    rst_n = 1'b0; clr = 1'b0; wr = 1'b0; rd = 1'b0; din = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_ae", int'(almost_empty), 1);
    chk("rst_waddr", int'(w_addr), 0);
    chk("rst_raddr", int'(r_addr), 0);
    rst_n = 1'b1;

    // Table-driven section
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      wr = vecs[i].wr; rd = vecs[i].rd; clr = vecs[i].clr;
      #1;
      chk($sformatf("v%0d_w_en", i), int'(w_en), int'(vecs[i].wen));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_count", i), int'(count), vecs[i].cnt);
      chk($sformatf("v%0d_full", i), int'(full), int'(vecs[i].fl));
      chk($sformatf("v%0d_empty", i), int'(empty), int'(vecs[i].em));
      chk($sformatf("v%0d_af", i), int'(almost_full), int'(vecs[i].af));
      chk($sformatf("v%0d_ae", i), int'(almost_empty), int'(vecs[i].ae));
      chk($sformatf("v%0d_ovf", i), int'(overflow), int'(vecs[i].ov));
      chk($sformatf("v%0d_unf", i), int'(underflow), int'(vecs[i].un));
      chk($sformatf("v%0d_waddr", i), int'(w_addr), vecs[i].wa);
      chk($sformatf("v%0d_raddr", i), int'(r_addr), vecs[i].ra);
      $display("vec %0d: wr=%0d rd=%0d clr=%0d w_en=%0d count=%0d w_addr=%0d r_addr=%0d",
               i, vecs[i].wr, vecs[i].rd, vecs[i].clr, w_en, count, w_addr, r_addr);
    end

    // Flush so that both pointers start from 0 for the wrap test.
    @(negedge clk);
    wr = 1'b0; rd = 1'b0; clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    #1;
    chk("flush_count", int'(count), 0);

    // Pointer wrap: push one word, pop it the next cycle, twenty times.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      wr = 1'b1; rd = 1'b0; din = 8'(i);
      @(negedge clk);
      wr = 1'b0; rd = 1'b1;
      #1;
      chk($sformatf("wrap%0d_empty", i), int'(empty), 0);
      chk($sformatf("wrap%0d_head", i), int'(mem[r_addr]), i);
      @(posedge clk);
      #1;
      chk($sformatf("wrap%0d_raddr", i), int'(r_addr), (i + 1) % 16);
      chk($sformatf("wrap%0d_waddr", i), int'(w_addr), (i + 1) % 16);
      $display("wrap %0d: head=0x%02h r_addr=%0d w_addr=%0d", i, mem[(i % 16)], r_addr, w_addr);
    end
    @(negedge clk);
    rd = 1'b0;

    // Five pushes, then clr together with wr.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      wr = 1'b1;
    end
    @(negedge clk);
    clr = 1'b1; wr = 1'b1;
    #1;
    chk("clr_w_en", int'(w_en), 0);
    @(posedge clk);
    #1;
    chk("clr_count", int'(count), 0);
    chk("clr_empty", int'(empty), 1);
    chk("clr_waddr", int'(w_addr), 0);
    chk("clr_ovf", int'(overflow), 0);
    $display("clr: count=%0d empty=%0d w_addr=%0d", count, empty, w_addr);

    // Asynchronous reset in the middle of a burst, checked with the clock low.
    @(negedge clk);
    clr = 1'b0; wr = 1'b1;
    repeat (3) @(negedge clk);
    wr = 1'b0;
    #1;
    chk("pre_arst_count", int'(count), 3);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_count", int'(count), 0);
    chk("arst_empty", int'(empty), 1);
    chk("arst_full", int'(full), 0);
    chk("arst_ae", int'(almost_empty), 1);
    chk("arst_af", int'(almost_full), 0);
    chk("arst_waddr", int'(w_addr), 0);
    chk("arst_raddr", int'(r_addr), 0);
    chk("arst_ovf", int'(overflow), 0);
    chk("arst_unf", int'(underflow), 0);
    $display("async reset: count=%0d empty=%0d w_addr=%0d", count, empty, w_addr);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_fifo_ctrl.md
Name: uart_fifo_ctrl

Overview:
Pointer and flag controller for the UART TX/RX FIFOs. It sits directly upstream of the FIFO register-file storage and drives that storage's w_en, w_addr and r_addr. It accepts push/pop requests from the UART transmitter, receiver and host side, and reports full, empty, almost-full, almost-empty, occupancy and error status. The storage has a registered write and a combinational read, so this controller behaves as first-word-fall-through.

Parameters:
- ADDR_WIDTH, 4: pointer width; FIFO depth DEPTH = 2**ADDR_WIDTH.
- AF_LEVEL, 14: almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 2: almost_empty asserts when count <= AE_LEVEL.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous flush; highest priority after reset.
- wr  in  1  push request; data is presented to storage by the producer.
- rd  in  1  pop request; consumer takes the head word the same cycle.
- w_en  out  1  storage write enable.
- w_addr  out  ADDR_WIDTH  storage write address (= wptr).
- r_addr  out  ADDR_WIDTH  storage read address (= rptr).
- full  out  1  count == DEPTH (registered).
- empty  out  1  count == 0 (registered).
- almost_full  out  1  registered.
- almost_empty  out  1  registered.
- count  out  ADDR_WIDTH+1  occupancy, 0..DEPTH (registered).
- overflow  out  1  one-cycle pulse on a rejected push.
- underflow  out  1  one-cycle pulse on a rejected pop.

Behaviour:
- Reset (rst_n=0, async), and clr=1 at a clock edge: wptr=0, rptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0.
- clr overrides wr/rd in the same cycle: nothing is accepted and no error pulses are raised.
- Accept rules, using registered flags:
  - push_ok = wr & (~full | rd)
  - pop_ok = rd & ~empty
  - When full, a simultaneous wr+rd accepts both; count is unchanged.
  - When empty, a simultaneous wr+rd accepts only the write; rd is rejected and underflow pulses.
- w_en = push_ok, combinational, same cycle as wr. Storage latches the data at the same edge that wptr increments.
- r_addr = rptr, combinational. The head word is valid whenever empty=0, with zero read latency. pop_ok advances rptr at the edge.
- Pointer wrap: wptr and rptr increment modulo DEPTH (DEPTH-1 -> 0). There is no extra wrap bit; full/empty are derived from count.
- count_next = count + push_ok - pop_ok, width ADDR_WIDTH+1. It never exceeds DEPTH and never goes below 0.
- Flags are computed from count_next and registered, so they update in the cycle after the causing edge:
  - full = (count_next == DEPTH)
  - empty = (count_next == 0)
  - almost_full = (count_next >= AF_LEVEL)
  - almost_empty = (count_next <= AE_LEVEL)
- overflow is registered, =1 for one cycle after an edge where wr & ~push_ok.
- underflow is registered, =1 for one cycle after an edge where rd & ~pop_ok.
- Async reset mid-burst clears everything immediately; storage contents are don't-care afterwards.
- Constraints: 0 < AE_LEVEL < AF_LEVEL < DEPTH.
- No combinational path from wr/rd to any flag output.

Test Plan:
- Reset then idle → empty=1, full=0, count=0, w_addr=0, r_addr=0, almost_empty=1.
- 16 pushes (DEPTH=16), no pops → w_en high 16 cycles, w_addr 0..15; almost_full=1 after the 14th push; full=1 and count=16 after the 16th push; w_addr wraps to 0.
- When full, wr only → w_en=0, overflow pulses one cycle, count stays 16. Then wr+rd together → w_en=1, r_addr advances 0→1, count stays 16, full stays 1.
- When empty, rd only → underflow pulses, r_addr unchanged. Then wr+rd together → write accepted, underflow=1, count=1, empty=0 next cycle.
- Pointer wrap: 20 push/pop pairs interleaved (push, then pop next cycle) → r_addr and w_addr each go 15→0; each head word read matches the pushed sequence 0x00..0x13.
- Push 5 words, assert clr with wr=1 → count=0, empty=1, no w_en that cycle. Separately, deassert rst_n asynchronously mid-burst → all outputs reach reset values without waiting for a clock edge.
